// File: rtl/cfg_rom_sequencer.sv
// Walks a register-init table in a synchronous ROM and turns each entry into a
// register write, a timed delay or end-of-table; writes leave over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start, nothing run yet (or after reset)
// FETCH  | rom_addr held, waiting ROM_LATENCY cycles for read data
// DECODE | sample rom_rd_data and dispatch on opcode
// ISSUE  | cmd_valid held until cmd_ready
// DELAY  | counting ticks x DELAY_UNIT cycles
// DONE   | sequence finished, done sticky, behaves like IDLE
module cfg_rom_sequencer #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int ROM_LATENCY = 2,
   parameter int NUM_ENTRIES = 1024,
   parameter int DELAY_UNIT  = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_rd_data_i,
   output logic                  cmd_valid_o,
   input  logic                  cmd_ready_i,
   output logic [15:0]           cmd_reg_o,
   output logic [7:0]            cmd_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [ADDR_WIDTH-1:0] wr_count_o
);

   localparam int SUB_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
   localparam logic [SUB_W-1:0]      SUB_MAX   = SUB_W'(DELAY_UNIT - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);
   localparam logic [2:0]            LAT       = 3'(ROM_LATENCY);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_DELAY = 2'b01;
   localparam logic [1:0] OP_END   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DELAY, S_DONE
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   rom_addr_q;
   logic [ADDR_WIDTH-1:0]   wr_count_q;
   logic [2:0]              fetch_cnt_q;
   logic [15:0]             tick_q;
   logic [SUB_W-1:0]        sub_q;
   logic                    cmd_valid_q;
   logic [15:0]             cmd_reg_q;
   logic [7:0]              cmd_data_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    err_q;

   logic [1:0]              opcode;
   logic [15:0]             ticks;
   logic                    advance_d;
   logic                    unused_rom_bits;

   assign opcode          = rom_rd_data_i[31:30];
   assign ticks           = rom_rd_data_i[15:0];
   assign unused_rom_bits = ^rom_rd_data_i[29:24];

   // Every path that finishes with the current entry and moves to the next one.
   always_comb begin
      advance_d = 1'b0;
      case (state_q)
         S_DECODE: advance_d = (opcode == OP_DELAY && ticks == 16'd0) ||
                               (opcode != OP_WRITE && opcode != OP_DELAY && opcode != OP_END);
         S_ISSUE:  advance_d = cmd_ready_i;
         S_DELAY:  advance_d = (sub_q == '0) && (tick_q == 16'd1);
         default:  advance_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rom_addr_q  <= '0;
         wr_count_q  <= '0;
         fetch_cnt_q <= '0;
         tick_q      <= '0;
         sub_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_reg_q   <= '0;
         cmd_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  rom_addr_q  <= '0;
                  wr_count_q  <= '0;
                  done_q      <= 1'b0;
                  err_q       <= 1'b0;
                  busy_q      <= 1'b1;
                  fetch_cnt_q <= LAT;
                  state_q     <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (fetch_cnt_q == 3'd0) state_q <= S_DECODE;
               else                     fetch_cnt_q <= fetch_cnt_q - 3'd1;
            end
            S_DECODE: begin
               case (opcode)
                  OP_WRITE: begin
                     cmd_reg_q   <= rom_rd_data_i[23:8];
                     cmd_data_q  <= rom_rd_data_i[7:0];
                     cmd_valid_q <= 1'b1;
                     state_q     <= S_ISSUE;
                  end
                  OP_DELAY: begin
                     if (ticks != 16'd0) begin
                        tick_q  <= ticks;
                        sub_q   <= SUB_MAX;
                        state_q <= S_DELAY;
                     end
                  end
                  OP_END: begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
                  default: err_q <= 1'b1;
               endcase
            end
            S_ISSUE: begin
               if (cmd_ready_i) begin
                  cmd_valid_q <= 1'b0;
                  wr_count_q  <= wr_count_q + 1'b1;
               end
            end
            S_DELAY: begin
               if (sub_q == '0) begin
                  tick_q <= tick_q - 16'd1;
                  sub_q  <= SUB_MAX;
               end else begin
                  sub_q <= sub_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // Overrides the per-state next state; the table never wraps.
         if (advance_d) begin
            if (rom_addr_q == LAST_ADDR) begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end else begin
               rom_addr_q  <= rom_addr_q + 1'b1;
               fetch_cnt_q <= LAT;
               state_q     <= S_FETCH;
            end
         end
      end
   end

   assign rom_addr_o  = rom_addr_q;
   assign cmd_valid_o = cmd_valid_q;
   assign cmd_reg_o   = cmd_reg_q;
   assign cmd_data_o  = cmd_data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_cfg_rom_sequencer.sv
// Scoreboard bench for cfg_rom_sequencer: a table-walking reference model queues
// the expected commands and their timing, an independent monitor checks them.
module tb_cfg_rom_sequencer;

   localparam int AW    = 4;
   localparam int LAT   = 2;
   localparam int NUM_E = 4;
   localparam int DU    = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic [AW-1:0] rom_addr_o;
   logic [31:0]   rom_rd_data = '0;
   logic [31:0]   rom_p1 = '0;
   logic          cmd_valid_o;
   logic          cmd_ready_i = 1'b0;
   logic [15:0]   cmd_reg_o;
   logic [7:0]    cmd_data_o;
   logic          busy_o, done_o, err_o;
   logic [AW-1:0] wr_count_o;

   cfg_rom_sequencer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(32), .ROM_LATENCY(LAT),
      .NUM_ENTRIES(NUM_E), .DELAY_UNIT(DU)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .rom_addr_o(rom_addr_o),
      .rom_rd_data_i(rom_rd_data), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
      .cmd_reg_o(cmd_reg_o), .cmd_data_o(cmd_data_o), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o), .wr_count_o(wr_count_o)
   );

   typedef struct {
      logic [15:0] r;
      logic [7:0]  d;
      int          gap;
      bit          first;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] rom_mem [16];
   int          n_vec = 0, n_err = 0;
   int          cyc = 0, start_cyc = 0, acc_cyc = 0, done_cyc = 0;
   int          exp_wr, exp_addr, exp_tot;
   bit          exp_err;
   int          ready_mode = 0;
   bit          prev_valid = 1'b0;
   logic [15:0] held_reg;
   logic [7:0]  held_data;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   // Two-stage registered ROM: data valid two edges after the address changes.
   initial forever begin
      @(posedge clk);
      rom_p1      <= rom_mem[rom_addr_o];
      rom_rd_data <= rom_p1;
   end

   initial forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
         0:       cmd_ready_i = 1'b1;
         1:       cmd_ready_i = ($urandom_range(0, 2) != 0);
         default: cmd_ready_i = 1'b0;
      endcase
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] wr(input logic [15:0] r, input logic [7:0] d);
      return {2'b00, 6'h00, r, d};
   endfunction

   function automatic logic [31:0] dly(input logic [15:0] t);
      return {2'b01, 14'h0000, t};
   endfunction

   localparam logic [31:0] END_W = 32'hC000_0000;
   localparam logic [31:0] RSV_W = 32'h8012_3456;

   task automatic load_table(input logic [31:0] a, b, c, d);
      rom_mem[0] = a; rom_mem[1] = b; rom_mem[2] = c; rom_mem[3] = d;
      for (int i = 4; i < 16; i++) rom_mem[i] = wr(16'hBEEF, 8'(i));
   endtask

   // Reference: walk the table entry by entry; each entry costs LAT+2 cycles to
   // reach its decode, writes cost one more cycle if accepted at once, delays
   // add ticks*DU, END stops; the table also stops after entry NUM_E-1.
   task automatic model_run();
      int gap, tot;
      bit first, fin;
      logic [31:0] w;
      gap = 0; tot = 0; first = 1'b1; fin = 1'b0;
      exp_wr = 0; exp_err = 1'b0; exp_addr = 0;
      for (int i = 0; i < NUM_E; i++) begin
         if (!fin) begin
            w = rom_mem[i];
            exp_addr = i;
            gap += LAT + 2;
            tot += LAT + 2;
            case (w[31:30])
               2'b00: begin
                  exp_q.push_back(exp_t'{w[23:8], w[7:0], gap, first});
                  first = 1'b0; gap = 0; exp_wr++; tot += 1;
               end
               2'b01: begin
                  gap += int'(w[15:0]) * DU;
                  tot += int'(w[15:0]) * DU;
               end
               2'b10:   exp_err = 1'b1;
               default: fin = 1'b1;
            endcase
         end
      end
      exp_tot = tot;
   endtask

   task automatic pulse_start(input bit record);
      @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      if (record) start_cyc = cyc;
   endtask

   task automatic start_run();
      model_run();
      pulse_start(1'b1);
      chk("start_busy", busy_o, 1);
      chk("start_done_clr", done_o, 0);
      chk("start_err_clr", err_o, 0);
      chk("start_wr_count", wr_count_o, 0);
      chk("start_rom_addr", rom_addr_o, 0);
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (!cmd_valid_o && k < budget) begin @(negedge clk); k++; end
      chk("wait_cmd_valid_timeout", cmd_valid_o, 1);
   endtask

   task automatic finish_run(input bit check_tot);
      int k = 0;
      while (!done_o && k < 3000) begin @(negedge clk); k++; end
      done_cyc = cyc;
      chk("end_done", done_o, 1);
      chk("end_busy", busy_o, 0);
      chk("end_err", err_o, exp_err);
      chk("end_wr_count", wr_count_o, exp_wr);
      chk("end_rom_addr", rom_addr_o, exp_addr);
      chk("end_pending_cmds", exp_q.size(), 0);
      if (check_tot) chk("run_cycles", done_cyc - start_cyc, exp_tot);
      exp_q.delete();
      repeat (2) @(posedge clk);
   endtask

   // Monitor: timing of each cmd_valid rise, payload, and stability while stalled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
         end else begin
            chk("busy_and_done", busy_o & done_o, 0);
            if (cmd_valid_o) begin
               if (!prev_valid) begin
                  if (exp_q.size() == 0) begin
                     n_vec++; n_err++;
                     $display("FAIL unexpected_cmd: got reg 0x%0h data 0x%0h, expected none", cmd_reg_o, cmd_data_o);
                  end else begin
                     e = exp_q[0];
                     chk("cmd_gap", cyc - (e.first ? start_cyc : acc_cyc), e.gap);
                     chk("cmd_reg", cmd_reg_o, e.r);
                     chk("cmd_data", cmd_data_o, e.d);
                  end
               end else begin
                  chk("hold_reg", cmd_reg_o, held_reg);
                  chk("hold_data", cmd_data_o, held_data);
               end
               held_reg  = cmd_reg_o;
               held_data = cmd_data_o;
               if (cmd_ready_i) begin
                  acc_cyc = cyc + 1;
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
               end
            end
            prev_valid = cmd_valid_o;
         end
      end
   end

   initial begin
      int k;
      logic [31:0] t [4];
      int op;
      load_table(END_W, END_W, END_W, END_W);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_cmd_valid", cmd_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_wr_count", wr_count_o, 0);
      chk("rst_rom_addr", rom_addr_o, 0);
      chk("rst_cmd_reg", cmd_reg_o, 0);
      chk("rst_cmd_data", cmd_data_o, 0);

      // basic two-write table, then an immediate identical rerun
      load_table(wr(16'h3008, 8'h82), wr(16'h3103, 8'h03), END_W, END_W);
      ready_mode = 0;
      start_run(); finish_run(1'b1);
      start_run(); finish_run(1'b1);

      // first command stalled for five cycles
      ready_mode = 2;
      start_run();
      wait_valid(50);
      repeat (5) @(posedge clk);
      ready_mode = 0;
      finish_run(1'b0);

      // delay of 3 ticks, then a zero-tick delay
      load_table(dly(16'd3), wr(16'h0001, 8'h55), END_W, END_W);
      start_run(); finish_run(1'b1);
      load_table(dly(16'd0), wr(16'h0001, 8'h55), END_W, END_W);
      start_run(); finish_run(1'b1);

      // no END word, reserved opcode at index 1
      load_table(wr(16'h0100, 8'h01), RSV_W, wr(16'h0200, 8'h02), wr(16'h0300, 8'h03));
      start_run(); finish_run(1'b1);

      // start while busy is ignored; reset in the middle of an ISSUE
      load_table(wr(16'h1111, 8'h11), RSV_W, wr(16'h2222, 8'h22), END_W);
      ready_mode = 0;
      start_run();
      k = 0;
      while (wr_count_o != 1 && k < 100) begin @(negedge clk); k++; end
      chk("mid_wr_count", wr_count_o, 1);
      ready_mode = 2;
      pulse_start(1'b0);
      wait_valid(50);
      chk("mid_err", err_o, 1);
      chk("mid_busy", busy_o, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_cmd_valid", cmd_valid_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_done", done_o, 0);
      chk("arst_err", err_o, 0);
      chk("arst_wr_count", wr_count_o, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      ready_mode = 0;
      start_run(); finish_run(1'b1);

      // randomized tables with random backpressure
      for (int run = 0; run < 25; run++) begin
         for (int i = 0; i < 4; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 5)      t[i] = wr(16'($urandom), 8'($urandom));
            else if (op <= 7) t[i] = dly(16'($urandom_range(0, 2)));
            else if (op == 8) t[i] = {2'b10, 30'($urandom)};
            else              t[i] = {2'b11, 30'($urandom)};
         end
         load_table(t[0], t[1], t[2], t[3]);
         ready_mode = 1;
         start_run();
         finish_run(1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
